// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA polling controller.
// Register selects, status bit positions, FSM states and bus bundle.
package acia_pkg;

  localparam logic RS_CTRL = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int RXF = 0;
  localparam int TXE = 1;
  localparam int FE  = 4;
  localparam int OVR = 5;

  localparam logic [7:0] CTRL_MRESET = 8'h03;

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_CFG,
    IDLE,
    STAT_RD,
    STAT_WAIT,
    DATA_RD,
    DATA_WAIT,
    DATA_WR
  } state_e;

  typedef struct packed {
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] wdata;
  } bus_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_hold.sv
// One-entry valid/ready holding register.
// Loads only when empty, so a load and an unload never share a cycle.
module byte_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Capture when empty, release on downstream accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end else if (out_ready_i && full_q) begin
      full_q <= 1'b0;
    end
  end

  assign in_ready_o  = ~full_q;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/acia_poller.sv
// Polls an ACIA status register and moves bytes between the ACIA
// and one-entry tx/rx holding registers using single-cycle strobes.
module acia_poller
  import acia_pkg::*;
#(
  parameter logic [7:0] CTRL_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_wdata,
  input  logic [7:0] acia_rdata,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] err_count,
  output logic       init_done
);

  state_e     state_q, state_d;
  state_e     seq_end;
  logic       run_q;
  logic       init_q;
  logic [7:0] err_q, err_d;
  bus_t       bus;

  logic       tx_full;
  logic       tx_drain;
  logic [7:0] tx_byte;
  logic       rx_room;
  logic       rx_load;
  logic       stat_err;

  assign tx_drain = (state_q == DATA_WR);
  assign rx_load  = (state_q == DATA_WAIT);
  assign stat_err = acia_rdata[FE] | acia_rdata[OVR];
  assign seq_end  = enable ? STAT_RD : IDLE;
  assign err_d    = (state_q == STAT_WAIT && stat_err) ?
                    sat_inc(err_q) : err_q;

  // State register; run_q holds off the first init write
  // until the cycle after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT_RST;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Init completion flag and saturating status error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      err_q  <= 8'h00;
    end else begin
      init_q <= init_q | (state_q == INIT_CFG);
      err_q  <= err_d;
    end
  end

  // Next-state: rx service wins over tx when both are possible.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT_RST:  state_d = run_q ? INIT_CFG : INIT_RST;
      INIT_CFG:  state_d = IDLE;
      IDLE:      state_d = enable ? STAT_RD : IDLE;
      STAT_RD:   state_d = STAT_WAIT;
      STAT_WAIT: begin
        if (acia_rdata[RXF] && rx_room)
          state_d = DATA_RD;
        else if (acia_rdata[TXE] && tx_full)
          state_d = DATA_WR;
        else
          state_d = seq_end;
      end
      DATA_RD:   state_d = DATA_WAIT;
      DATA_WAIT: state_d = seq_end;
      DATA_WR:   state_d = seq_end;
      default:   state_d = INIT_RST;
    endcase
  end

  // Bus strobe decode from the current state.
  always_comb begin
    bus = '0;
    unique case (state_q)
      INIT_RST: begin
        if (run_q) begin
          bus.cs    = 1'b1;
          bus.we    = 1'b1;
          bus.rs    = RS_CTRL;
          bus.wdata = CTRL_MRESET;
        end
      end
      INIT_CFG: begin
        bus.cs    = 1'b1;
        bus.we    = 1'b1;
        bus.rs    = RS_CTRL;
        bus.wdata = CTRL_INIT;
      end
      STAT_RD: begin
        bus.cs = 1'b1;
        bus.rs = RS_CTRL;
      end
      DATA_RD: begin
        bus.cs = 1'b1;
        bus.rs = RS_DATA;
      end
      DATA_WR: begin
        bus.cs    = 1'b1;
        bus.we    = 1'b1;
        bus.rs    = RS_DATA;
        bus.wdata = tx_byte;
      end
      default: bus = '0;
    endcase
  end

  byte_hold #(.W(8)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (tx_data),
    .in_valid_i  (tx_valid),
    .in_ready_o  (tx_ready),
    .out_data_o  (tx_byte),
    .out_valid_o (tx_full),
    .out_ready_i (tx_drain)
  );

  byte_hold #(.W(8)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (acia_rdata),
    .in_valid_i  (rx_load),
    .in_ready_o  (rx_room),
    .out_data_o  (rx_data),
    .out_valid_o (rx_valid),
    .out_ready_i (rx_ready)
  );

  assign acia_cs    = bus.cs;
  assign acia_we    = bus.we;
  assign acia_rs    = bus.rs;
  assign acia_wdata = bus.wdata;
  assign err_count  = err_q;
  assign init_done  = init_q;

endmodule

// File: tb/tb_acia_poller.sv
// Randomized bench for acia_poller with a transaction-schedule
// reference model and an ACIA responder driven by that model.
module tb_acia_poller;

  localparam logic [7:0] CFG = 8'h80;
  localparam int K_I0 = 0;
  localparam int K_I1 = 1;
  localparam int K_ST = 2;
  localparam int K_DR = 3;
  localparam int K_DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       acia_cs, acia_we, acia_rs;
  logic [7:0] acia_wdata, acia_rdata;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] err_count;
  logic       init_done;

  always #5 clk = ~clk;

  acia_poller #(.CTRL_INIT(CFG)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .acia_cs    (acia_cs),
    .acia_we    (acia_we),
    .acia_rs    (acia_rs),
    .acia_wdata (acia_wdata),
    .acia_rdata (acia_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .err_count  (err_count),
    .init_done  (init_done)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // model: next expected strobe, pending decision, pending rx load
  int         sched_t, sched_k;
  int         dec_t, load_t, rd_due;
  logic [7:0] dec_s, load_d, rd_val;
  bit         m_idle, m_txf, m_rxf, m_init;
  logic [7:0] m_txb, m_rxb;
  int         m_err;

  int en_pct  = 90;
  int txv_pct = 40;
  int rxr_pct = 50;
  int st_mode = -1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                 tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] gen_status();
    logic [7:0] s;
    if (st_mode >= 0) return st_mode[7:0];
    s = 8'($urandom);
    if ($urandom_range(9) != 0) s[5:4] = 2'b00;
    return s;
  endfunction

  task automatic model_reset();
    sched_t = -1; sched_k = 0;
    dec_t = -1; load_t = -1; rd_due = -1;
    m_idle = 0; m_txf = 0; m_rxf = 0; m_init = 0;
    m_txb = 8'h00; m_rxb = 8'h00; m_err = 0;
  endtask

  task automatic check_now();
    bit e;
    e = (sched_t == cyc);
    chk("cs", 32'(acia_cs), 32'(e));
    if (e) begin
      case (sched_k)
        K_I0: begin
          chk("i0_we", 32'(acia_we), 1);
          chk("i0_rs", 32'(acia_rs), 0);
          chk("i0_wd", 32'(acia_wdata), 32'h03);
        end
        K_I1: begin
          chk("i1_we", 32'(acia_we), 1);
          chk("i1_rs", 32'(acia_rs), 0);
          chk("i1_wd", 32'(acia_wdata), 32'(CFG));
        end
        K_ST: begin
          chk("st_we", 32'(acia_we), 0);
          chk("st_rs", 32'(acia_rs), 0);
        end
        K_DR: begin
          chk("dr_we", 32'(acia_we), 0);
          chk("dr_rs", 32'(acia_rs), 1);
        end
        default: begin
          chk("dw_we", 32'(acia_we), 1);
          chk("dw_rs", 32'(acia_rs), 1);
          chk("dw_wd", 32'(acia_wdata), 32'(m_txb));
        end
      endcase
    end
    chk("tx_ready", 32'(tx_ready), 32'(!m_txf));
    chk("rx_valid", 32'(rx_valid), 32'(m_rxf));
    if (m_rxf) chk("rx_data", 32'(rx_data), 32'(m_rxb));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("init_done", 32'(init_done), 32'(m_init));
  endtask

  task automatic drive();
    acia_rdata = (rd_due == cyc) ? rd_val : 8'($urandom);
    enable     = ($urandom_range(99) < en_pct);
    tx_valid   = ($urandom_range(99) < txv_pct);
    tx_data    = 8'($urandom);
    rx_ready   = ($urandom_range(99) < rxr_pct);
  endtask

  task automatic model_step();
    bit e, end_seq, drain, do_load, cons, acc;
    if (rst) return;
    e = enable; end_seq = 0; drain = 0; do_load = 0;
    if (m_idle && e) begin
      sched_t = cyc + 1; sched_k = K_ST; m_idle = 0;
    end else if (sched_t == cyc) begin
      sched_t = -1;
      case (sched_k)
        K_I0: begin sched_t = cyc + 1; sched_k = K_I1; end
        K_I1: begin m_init = 1; m_idle = 1; end
        K_ST: begin
          dec_s = gen_status(); dec_t = cyc + 1;
          rd_val = dec_s; rd_due = cyc + 1;
        end
        K_DR: begin
          load_d = 8'($urandom); load_t = cyc + 1;
          rd_val = load_d; rd_due = cyc + 1;
        end
        default: begin drain = 1; end_seq = 1; end
      endcase
    end
    if (dec_t == cyc) begin
      dec_t = -1;
      if ((dec_s[5] || dec_s[4]) && m_err < 255) m_err++;
      if (dec_s[0] && !m_rxf) begin
        sched_t = cyc + 1; sched_k = K_DR;
      end else if (dec_s[1] && m_txf) begin
        sched_t = cyc + 1; sched_k = K_DW;
      end else end_seq = 1;
    end
    if (load_t == cyc) begin
      load_t = -1; do_load = 1; end_seq = 1;
    end
    cons = m_rxf && rx_ready;
    acc  = tx_valid && !m_txf;
    if (cons) m_rxf = 0;
    if (do_load) begin m_rxf = 1; m_rxb = load_d; end
    if (drain) m_txf = 0;
    if (acc) begin m_txf = 1; m_txb = tx_data; end
    if (end_seq) begin
      if (e) begin sched_t = cyc + 1; sched_k = K_ST; end
      else m_idle = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_now();
    drive();
    model_step();
  endtask

  task automatic release_rst();
    @(negedge clk);
    cyc++;
    check_now();
    rst = 1'b0;
    drive();
    sched_t = cyc + 1;
    sched_k = K_I0;
    model_step();
  endtask

  initial begin
    bit found;
    rst = 1'b1; enable = 0; tx_valid = 0; tx_data = 0;
    rx_ready = 0; acia_rdata = 0;
    model_reset();
    #1;
    chk("rst_cs", 32'(acia_cs), 0);
    chk("rst_rxd", 32'(rx_data), 0);
    chk("rst_wd", 32'(acia_wdata), 0);
    repeat (3) tick();
    release_rst();
    repeat (3) tick();
    chk("init_seen", 32'(init_done), 1);

    repeat (3000) tick();
    en_pct = 30;
    repeat (600) tick();

    en_pct = 100; st_mode = 8'h01; rxr_pct = 0;
    repeat (100) tick();
    chk("rx_held", 32'(rx_valid), 1);

    st_mode = 8'h03; txv_pct = 100; rxr_pct = 40;
    repeat (300) tick();

    st_mode = 8'h30; txv_pct = 40; rxr_pct = 50;
    repeat (800) tick();
    chk("err_sat", 32'(err_count), 32'hFF);
    st_mode = -1;
    repeat (200) tick();
    chk("err_nowrap", 32'(err_count), 32'hFF);

    st_mode = 8'h02; txv_pct = 100;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (sched_t == cyc + 1 && sched_k == K_DW) found = 1;
    end
    chk("dwr_found", 32'(found), 1);
    if (found) begin
      @(negedge clk);
      cyc++;
      check_now();
      rst = 1'b1;
      #1;
      chk("arst_cs", 32'(acia_cs), 0);
      chk("arst_we", 32'(acia_we), 0);
      chk("arst_wd", 32'(acia_wdata), 0);
      chk("arst_txr", 32'(tx_ready), 1);
      chk("arst_init", 32'(init_done), 0);
      chk("arst_err", 32'(err_count), 0);
      model_reset();
      repeat (2) tick();
      txv_pct = 0;
      release_rst();
      repeat (20) tick();
      chk("post_txr", 32'(tx_ready), 1);
      txv_pct = 50; st_mode = -1; en_pct = 90;
      repeat (500) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/acia_poller.md
ACIA_POLLER -- requirements
Module: acia_poller

Interface
REQ-001 Parameter CTRL_INIT, default 8'h00, SHALL be the control word written after the ACIA master reset (bit7 rx irq enable, bits6:5 tx control, bits4:2 word select, bits1:0 divide select).
REQ-002 clk  input  1  system clock; one clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  high = poll/transfer; low = finish current access, then idle.
REQ-005 acia_cs  output  1  ACIA chip select.
REQ-006 acia_we  output  1  ACIA write enable.
REQ-007 acia_rs  output  1  ACIA register select: 0 = control/status, 1 = data.
REQ-008 acia_wdata  output  8  byte driven into the ACIA din.
REQ-009 acia_rdata  input  8  ACIA dout, registered, valid the cycle after a read strobe.
REQ-010 tx_data/tx_valid  input  8/1  transmit byte stream in.
REQ-011 tx_ready  output  1  high = tx holding register empty.
REQ-012 rx_data/rx_valid  output  8/1  received byte stream out.
REQ-013 rx_ready  input  1  consumer accepts rx byte.
REQ-014 err_count  output  8  saturating count of status reads with bit4 or bit5 set.
REQ-015 init_done  output  1  high once both init writes are complete.

Function
REQ-016 Every ACIA access SHALL be a single-cycle strobe: acia_cs high for exactly one cycle; a write drives we=1 with wdata in that cycle.
REQ-017 States: INIT_RST, INIT_CFG, IDLE, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, DATA_WR.
REQ-018 INIT_RST SHALL write 8'h03 with rs=0; INIT_CFG SHALL write CTRL_INIT with rs=0 in the next cycle; then IDLE, and init_done SHALL go high.
REQ-019 IDLE SHALL go to STAT_RD when enable=1; otherwise it stays in IDLE with cs=0.
REQ-020 STAT_RD SHALL strobe a read with rs=0; STAT_WAIT SHALL sample acia_rdata as status one cycle later.
REQ-021 In STAT_WAIT, decision order:
- status[0]=1 and rx holding empty -> DATA_RD;
- else status[1]=1 and tx holding full -> DATA_WR;
- else STAT_RD if enable, IDLE if not.
REQ-022 DATA_RD SHALL strobe a read with rs=1; DATA_WAIT SHALL load acia_rdata into rx holding, set rx_valid, then go to STAT_RD or IDLE per enable.
REQ-023 DATA_WR SHALL write tx holding with rs=1, clear tx holding in the same edge, then go to STAT_RD or IDLE per enable.
REQ-024 rx holding: one entry; rx_valid stays high until rx_valid&rx_ready; rx_data is stable while rx_valid.
REQ-025 If rx holding is full, the FSM SHALL NOT read the ACIA data register (ACIA overrun is accepted).
REQ-026 tx holding: one entry; tx_ready = ~full; capture on tx_valid&tx_ready.
REQ-027 A tx accept SHALL NOT coincide with a drain in the same cycle, because tx_ready is low while full.
REQ-028 An rx consume and an rx load SHALL NOT occur in the same cycle, because DATA_RD requires the holding register empty at STAT_WAIT; a consume during DATA_RD/DATA_WAIT SHALL be handled (empty then reload).
REQ-029 err_count SHALL increment by 1 per STAT_WAIT with status[5]|status[4], saturating at 8'hFF.
REQ-030 Throughput: rx byte every 4 cycles min (STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT); tx byte every 3 cycles min.
REQ-031 enable deasserted mid-sequence SHALL NOT abort a strobe or wait; the FSM reaches IDLE at the next sequence end.

Reset
REQ-032 rst SHALL immediately (asynchronously) force:
- acia_cs/we/rs=0, acia_wdata=8'h00, tx_ready=1, rx_valid=0, rx_data=8'h00, err_count=0, init_done=0;
- state INIT_RST; both holding registers empty.
REQ-033 After rst deasserts, init SHALL rerun; bytes held at reset are discarded.

Structure
REQ-034 Shared package acia_pkg SHALL hold:
- RS_CTRL=1'b0, RS_DATA=1'b1;
- status bit indices RXF=0, TXE=1, FE=4, OVR=5;
- CTRL_MRESET=8'h03;
- the state enum.
REQ-035 One sub-module, byte_hold (one-entry valid/ready register), SHALL be instantiated for tx and rx.

Verification
REQ-036 Reset release, CTRL_INIT=8'h80 -> writes 8'h03 then 8'h80 (rs=0) in consecutive cycles; init_done=1 next cycle.
REQ-037 tx_valid with 8'h55, status 8'h02 -> one write with rs=1, wdata=8'h55; tx_ready low until that write edge.
REQ-038 Status 8'h01, data 8'hA5, rx_ready=0 -> rx_data=8'hA5, rx_valid held; no further data reads while held.
REQ-039 Status 8'h03, both holding registers primed -> data read precedes data write.
REQ-040 300 status reads returning 8'h30 -> err_count=8'hFF, no wrap.
REQ-041 rst asserted during DATA_WR -> cs=0 immediately, no write issued; after release init repeats, tx holding empty.
